wb_arbiter: RTL and testbench

WB_ARBITER -- requirements
Module: wb_arbiter

---
 rtl/wb_arbiter_if.sv | 53 +++++
 rtl/wb_arbiter.sv | 138 +++++++++++++
 tb/tb_wb_arbiter.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/wb_arbiter_if.sv
// ---------------------------------------------------------------------------
// wb_arbiter_if
// Bundle of the writeback arbiter's request, response and register-file
// signals.
//
// Valid/ready rule for both request channels (alu_*, mdu_*): a transfer takes
// place on a rising edge where valid and ready are both 1. The ready signals
// depend only on internal state and reset, never on valid.
//
// Modports:
//   master : the requesting side (execute units / issue stage). It drives the
//            requests and issue info, and sees the readies, the register-file
//            write port and the pending scoreboard.
//   slave  : the arbiter itself.
// ---------------------------------------------------------------------------
interface wb_arbiter_if #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5
);
  logic                       alu_valid;
  logic [AddrRegWidth-1:0]    alu_rd;
  logic [DataWidth-1:0]       alu_data;
  logic                       alu_ready;

  logic                       mdu_valid;
  logic [AddrRegWidth-1:0]    mdu_rd;
  logic [DataWidth-1:0]       mdu_data;
  logic                       mdu_ready;

  logic                       issue_valid;
  logic [AddrRegWidth-1:0]    issue_rd;

  logic                       writeEn;
  logic [AddrRegWidth-1:0]    writeDataSel;
  logic [DataWidth-1:0]       writeData;
  logic [2**AddrRegWidth-1:0] pending;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output mdu_valid, mdu_rd, mdu_data,
    output issue_valid, issue_rd,
    input  alu_ready, mdu_ready,
    input  writeEn, writeDataSel, writeData, pending
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  mdu_valid, mdu_rd, mdu_data,
    input  issue_valid, issue_rd,
    output alu_ready, mdu_ready,
    output writeEn, writeDataSel, writeData, pending
  );
endinterface

// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
// Register-file writeback arbiter. It merges the single-cycle ALU result path
// with a small FIFO of multiply/divide (MDU) results onto one register-file
// write port, and keeps a scoreboard of registers with MDU writes still
// outstanding.
//
// Ports:
//   brq_clk : clock, all logic on the rising edge
//   brq_rst : synchronous, active-high reset
//   bus     : wb_arbiter_if.slave
//               alu_valid/alu_rd/alu_data/alu_ready  ALU writeback request
//               mdu_valid/mdu_rd/mdu_data/mdu_ready  MDU result into queue
//               issue_valid/issue_rd                 MDU op issued (sets pending)
//               writeEn/writeDataSel/writeData       registered write port
//               pending                              outstanding MDU writes
//
// Arbitration each cycle: a full queue drains first (the ALU is stalled), an
// accepted ALU result goes next, otherwise the queue head drains. The write
// appears on the port one edge later. x0 writes are consumed silently.
// ---------------------------------------------------------------------------
module wb_arbiter #(
  parameter int DataWidth    = 32,
  parameter int AddrRegWidth = 5,
  parameter int QueueDepth   = 2
) (
  input  logic       brq_clk,
  input  logic       brq_rst,
  wb_arbiter_if.slave bus
);

  localparam int EntryW = AddrRegWidth + DataWidth;
  localparam int PtrW   = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int CntW   = $clog2(QueueDepth + 1);
  localparam int NumReg = 2 ** AddrRegWidth;

  logic [EntryW-1:0]       mem [QueueDepth];
  logic [PtrW-1:0]         wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]         count_q;

  logic                    write_en_q;
  logic [AddrRegWidth-1:0] write_sel_q;
  logic [DataWidth-1:0]    write_data_q;
  logic [NumReg-1:0]       pending_q, pending_next;

  logic                    full, empty;
  logic                    accept_ok;
  logic                    alu_fire, mdu_push, q_pop;
  logic [AddrRegWidth-1:0] head_rd;
  logic [DataWidth-1:0]    head_data;
  logic                    sel_valid;
  logic [AddrRegWidth-1:0] sel_rd;
  logic [DataWidth-1:0]    sel_data;

  assign full      = (count_q == CntW'(QueueDepth));
  assign empty     = (count_q == '0);
  assign accept_ok = !brq_rst && !full;

  assign bus.alu_ready = accept_ok;
  assign bus.mdu_ready = accept_ok;

  assign alu_fire = bus.alu_valid && accept_ok;
  assign mdu_push = bus.mdu_valid && accept_ok;
  // A full queue has alu_fire == 0, so this single term covers both the
  // "drain when full" and "drain when the ALU is idle" cases. The decision
  // uses the count before this cycle's push, so a new entry is never popped
  // in the cycle it arrives.
  assign q_pop    = !empty && !alu_fire;

  assign head_rd   = mem[rd_ptr_q][EntryW-1:DataWidth];
  assign head_data = mem[rd_ptr_q][DataWidth-1:0];

  always_comb begin
    sel_valid = 1'b0;
    sel_rd    = '0;
    sel_data  = '0;
    if (q_pop) begin
      sel_valid = 1'b1;
      sel_rd    = head_rd;
      sel_data  = head_data;
    end else if (alu_fire) begin
      sel_valid = 1'b1;
      sel_rd    = bus.alu_rd;
      sel_data  = bus.alu_data;
    end
  end

  // Clear before set so that a new issue to the register being drained keeps
  // its pending bit.
  always_comb begin
    pending_next = pending_q;
    if (q_pop) pending_next[head_rd] = 1'b0;
    if (bus.issue_valid && (bus.issue_rd != '0)) pending_next[bus.issue_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  // Queue storage carries no reset; entries are only read while counted.
  always_ff @(posedge brq_clk) begin
    if (mdu_push) mem[wr_ptr_q] <= {bus.mdu_rd, bus.mdu_data};
  end

  always_ff @(posedge brq_clk) begin
    if (brq_rst) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      write_en_q   <= 1'b0;
      write_sel_q  <= '0;
      write_data_q <= '0;
      pending_q    <= '0;
    end else begin
      if (mdu_push) begin
        wr_ptr_q <= (wr_ptr_q == PtrW'(QueueDepth - 1)) ? '0 : wr_ptr_q + PtrW'(1);
      end
      if (q_pop) begin
        rd_ptr_q <= (rd_ptr_q == PtrW'(QueueDepth - 1)) ? '0 : rd_ptr_q + PtrW'(1);
      end
      if (mdu_push && !q_pop) begin
        count_q <= count_q + CntW'(1);
      end else if (q_pop && !mdu_push) begin
        count_q <= count_q - CntW'(1);
      end

      write_en_q <= sel_valid && (sel_rd != '0);
      if (sel_valid && (sel_rd != '0)) begin
        write_sel_q  <= sel_rd;
        write_data_q <= sel_data;
      end
      pending_q <= pending_next;
    end
  end

  assign bus.writeEn      = write_en_q;
  assign bus.writeDataSel = write_sel_q;
  assign bus.writeData    = write_data_q;
  assign bus.pending      = pending_q;

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int QD = 2;
  localparam int NR = 32;
  localparam int EW = NR + 1 + AW + DW;

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wb_arbiter_if #(.DataWidth(DW), .AddrRegWidth(AW)) bus ();

  wb_arbiter #(.DataWidth(DW), .AddrRegWidth(AW), .QueueDepth(QD)) dut (
    .brq_clk (clk),
    .brq_rst (rst),
    .bus     (bus)
  );

  // ---------------- scoreboard ----------------
  // One entry per driven cycle: {pending, writeEn, writeDataSel, writeData}
  // expected after the edge that ends that cycle.
  logic [EW-1:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [AW+DW-1:0] mq[$];
  logic [NR-1:0]    m_pend;
  logic [AW-1:0]    m_sel;
  logic [DW-1:0]    m_data;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Compare the outputs produced by the previous cycle's edge.
  task automatic compare_head();
    logic [EW-1:0] e;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check_val("pending", 64'(bus.pending), 64'(e[EW-1:AW+DW+1]));
      check_val("write_en", 64'(bus.writeEn), 64'(e[AW+DW]));
      check_val("write_sel", 64'(bus.writeDataSel), 64'(e[AW+DW-1:DW]));
      check_val("write_data", 64'(bus.writeData), 64'(e[DW-1:0]));
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic av, input logic [AW-1:0] ard, input logic [DW-1:0] ad,
                      input logic mv, input logic [AW-1:0] mrd, input logic [DW-1:0] md,
                      input logic iv, input logic [AW-1:0] ird, input logic r);
    logic             ready, alu_fire, pop, push, en;
    logic [AW+DW-1:0] e;
    logic [AW-1:0]    wrd;
    logic [DW-1:0]    wdat;
    @(posedge clk);
    #1;
    compare_head();
    rst             = r;
    bus.alu_valid   = av;
    bus.alu_rd      = ard;
    bus.alu_data    = ad;
    bus.mdu_valid   = mv;
    bus.mdu_rd      = mrd;
    bus.mdu_data    = md;
    bus.issue_valid = iv;
    bus.issue_rd    = ird;
    #1;
    ready = !r && (mq.size() != QD);
    check_val("alu_ready", 64'(bus.alu_ready), 64'(ready));
    check_val("mdu_ready", 64'(bus.mdu_ready), 64'(ready));

    en = 1'b0;
    if (r) begin
      mq.delete();
      m_pend = '0;
      m_sel  = '0;
      m_data = '0;
    end else begin
      alu_fire = av && ready;
      push     = mv && ready;
      pop      = (mq.size() == QD) || (!alu_fire && mq.size() != 0);
      wrd  = '0;
      wdat = '0;
      if (pop) begin
        e    = mq.pop_front();
        wrd  = e[AW+DW-1:DW];
        wdat = e[DW-1:0];
        m_pend[wrd] = 1'b0;
      end else if (alu_fire) begin
        wrd  = ard;
        wdat = ad;
      end
      if ((pop || alu_fire) && wrd != '0) begin
        en     = 1'b1;
        m_sel  = wrd;
        m_data = wdat;
      end
      if (push) mq.push_back({mrd, md});
      if (iv && ird != '0) m_pend[ird] = 1'b1;
      m_pend[0] = 1'b0;
    end
    exp_q.push_back({m_pend, en, m_sel, m_data});
  endtask

  task automatic idle();
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  task automatic alu(input logic [AW-1:0] rd, input logic [DW-1:0] d);
    step(1'b1, rd, d, 1'b0, '0, '0, 1'b0, '0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    bus.alu_valid = 1'b0; bus.alu_rd = '0; bus.alu_data = '0;
    bus.mdu_valid = 1'b0; bus.mdu_rd = '0; bus.mdu_data = '0;
    bus.issue_valid = 1'b0; bus.issue_rd = '0;
    m_pend = '0; m_sel = '0; m_data = '0;

    // Reset with transfers presented: they must be ignored.
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd2, 32'h2, 1'b1, 5'd3, 1'b1);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle();
    check_val("reset_write_en", 64'(bus.writeEn), 64'd0);
    check_val("reset_pending", 64'(bus.pending), 64'd0);

    // ALU only.
    alu(5'd5, 32'hDEADBEEF);
    idle();
    check_val("alu_only_en", 64'(bus.writeEn), 64'd1);
    check_val("alu_only_data", 64'(bus.writeData), 64'hDEADBEEF);
    idle();
    check_val("alu_only_drop", 64'(bus.writeEn), 64'd0);
    check_val("alu_only_hold", 64'(bus.writeDataSel), 64'd5);

    // Priority: queued x7, then ALU x3 -> x3 first, then x7.
    step(1'b0, '0, '0, 1'b1, 5'd7, 32'h11, 1'b0, '0, 1'b0);
    alu(5'd3, 32'h33);
    idle();
    check_val("prio_first", 64'(bus.writeDataSel), 64'd3);
    idle();
    check_val("prio_second", 64'(bus.writeDataSel), 64'd7);
    idle();

    // Full queue with the ALU continuously valid.
    step(1'b1, 5'd4, 32'h44, 1'b1, 5'd8, 32'h88, 1'b0, '0, 1'b0);
    step(1'b1, 5'd4, 32'h45, 1'b1, 5'd9, 32'h99, 1'b0, '0, 1'b0);
    alu(5'd4, 32'h46);
    check_val("full_alu_ready", 64'(bus.alu_ready), 64'd0);
    check_val("full_mdu_ready", 64'(bus.mdu_ready), 64'd0);
    for (int i = 0; i < 3; i++) alu(5'd4, 32'h50 + 32'(i));
    idle();
    idle();
    idle();

    // Scoreboard set / clear / set-wins.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 1'b0);
    idle();
    check_val("sb_set", 64'(bus.pending[12]), 64'd1);
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'hC0, 1'b0, '0, 1'b0);
    idle();
    idle();
    check_val("sb_clear", 64'(bus.pending[12]), 64'd0);
    step(1'b0, '0, '0, 1'b1, 5'd12, 32'hC1, 1'b1, 5'd12, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd12, 1'b0);
    idle();
    check_val("sb_set_wins", 64'(bus.pending[12]), 64'd1);
    idle();

    // x0 result is consumed without a write.
    step(1'b0, '0, '0, 1'b1, 5'd0, 32'hBAD, 1'b1, 5'd0, 1'b0);
    idle();
    idle();
    check_val("x0_no_write", 64'(bus.writeEn), 64'd0);

    // Reset with two entries queued.
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b1, 5'd20, 1'b0);
    step(1'b1, 5'd1, 32'h1, 1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 1'b0);
    step(1'b1, 5'd1, 32'h2, 1'b1, 5'd21, 32'h21, 1'b0, '0, 1'b0);
    step(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0, 1'b1);
    idle();
    check_val("rst_q_pending", 64'(bus.pending), 64'd0);
    for (int i = 0; i < 3; i++) idle();

    // Random traffic against the model.
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
           1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
           1'($urandom_range(0, 49) == 0));
    end
    for (int i = 0; i < 4; i++) idle();
    @(posedge clk);
    #1;
    compare_head();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
